// File: rtl/sample_unpacker_pkg.sv
// Shared constants and helpers for the flash-word to audio-byte unpacker.
package sample_unpacker_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t FWD_FIRST = 2'd0;
  localparam byte_idx_t REV_FIRST = 2'd3;

  // Extract byte[idx] of a word; byte0 is the least significant byte.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                  input byte_idx_t idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Index of the first byte of a word in the given playback direction.
  function automatic byte_idx_t first_idx(input logic rev);
    return rev ? REV_FIRST : FWD_FIRST;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with registered full/empty flags and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the write even when the head is popped this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy; clear wins over any push or pop.
  always_comb begin
    level_next = level;
    if (clear)
      level_next = '0;
    else if (do_push && !do_pop)
      level_next = level + LW'(1);
    else if (do_pop && !do_push)
      level_next = level - LW'(1);
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= wdata;
  end

  // Pointers, level and flags; flags are registered from the next level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/sample_unpacker.sv
// Buffers 32-bit flash words and plays them out one byte per sample tick.
module sample_unpacker
  import sample_unpacker_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int UNDERRUN_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          enable,
  input  logic                          reverse,
  input  logic                          word_valid,
  input  logic [WORD_W-1:0]             word_data,
  output logic                          word_ready,
  input  logic                          sample_tick,
  output logic [BYTE_W-1:0]             audio_out,
  output logic                          audio_valid,
  output logic                          underrun,
  output logic [UNDERRUN_W-1:0]         underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [WORD_W-1:0] head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tick_ok;
  logic              have_data;
  logic              at_last;
  logic              do_pop;
  logic              do_push;
  byte_idx_t         byte_idx;
  logic              dir_lat;

  // word_ready comes straight from the registered full flag.
  assign word_ready = !fifo_full;
  assign tick_ok    = sample_tick && enable && !flush;
  assign have_data  = !fifo_empty;
  assign at_last    = dir_lat ? (byte_idx == FWD_FIRST) : (byte_idx == REV_FIRST);
  assign do_pop     = tick_ok && have_data && at_last;
  assign do_push    = word_valid && word_ready && !flush;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (word_data),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Byte sequencer: direction is relatched only at word boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_lat  <= 1'b0;
      byte_idx <= FWD_FIRST;
    end else if (flush || do_pop) begin
      dir_lat  <= reverse;
      byte_idx <= first_idx(reverse);
    end else if (tick_ok && have_data) begin
      byte_idx <= dir_lat ? byte_idx - 2'd1 : byte_idx + 2'd1;
    end
  end

  // Output sample register and one-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      audio_valid <= tick_ok && have_data;
      underrun    <= tick_ok && !have_data;
      if (!enable)
        audio_out <= '0;
      else if (tick_ok && have_data)
        audio_out <= word_byte(head_word, byte_idx);
    end
  end

  // Saturating count of ticks that found the FIFO empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underrun_count <= '0;
    else if (tick_ok && !have_data && (underrun_count != '1))
      underrun_count <= underrun_count + UNDERRUN_W'(1);
  end

endmodule

// File: tb/tb_sample_unpacker.sv
// Scoreboard bench for sample_unpacker: a queue-based reference model predicts
// each byte/underrun event; a negedge monitor pops and compares.
module tb_sample_unpacker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        enable = 1'b1;
  logic        reverse = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        sample_tick = 1'b0;

  logic        word_ready, audio_valid, underrun;
  logic [7:0]  audio_out;
  logic [15:0] underrun_count;
  logic [2:0]  fifo_level;

  logic        s_word_ready, s_audio_valid, s_underrun;
  logic [7:0]  s_audio_out;
  logic [1:0]  s_underrun_count;
  logic [2:0]  s_fifo_level;

  sample_unpacker #(.FIFO_DEPTH(DEPTH), .UNDERRUN_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .reverse(reverse),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .sample_tick(sample_tick), .audio_out(audio_out), .audio_valid(audio_valid),
    .underrun(underrun), .underrun_count(underrun_count), .fifo_level(fifo_level)
  );

  // Second instance with a 2-bit counter to exercise saturation cheaply.
  sample_unpacker #(.FIFO_DEPTH(DEPTH), .UNDERRUN_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .enable(enable), .reverse(reverse),
    .word_valid(word_valid), .word_data(word_data), .word_ready(s_word_ready),
    .sample_tick(sample_tick), .audio_out(s_audio_out), .audio_valid(s_audio_valid),
    .underrun(s_underrun), .underrun_count(s_underrun_count), .fifo_level(s_fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];     // words held, head at index 0
  int          m_idx;      // byte position within head word
  bit          m_rev;      // latched playback direction
  int          m_audio;
  int          m_cnt;
  int          m_cnt_sat;
  int          expq[$];    // expected events: byte value, or -1 for underrun
  int          obs_log[$]; // bytes seen on audio_valid, for directed checks

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete(); expq.delete();
      m_idx = 0; m_rev = 0; m_audio = 0; m_cnt = 0; m_cnt_sat = 0;
    end else begin
      bit tick_ok, had, push;
      tick_ok = sample_tick && enable && !flush;
      had     = (m_q.size() > 0);
      push    = word_valid && (m_q.size() < DEPTH) && !flush;
      if (flush) begin
        m_q.delete();
        m_rev = reverse;
        m_idx = reverse ? 3 : 0;
      end else begin
        if (tick_ok && had) begin
          int b;
          b = (m_q[0] >> (8 * m_idx)) & 8'hff;
          expq.push_back(b);
          if (enable) m_audio = b;
          if (m_idx == (m_rev ? 0 : 3)) begin
            void'(m_q.pop_front());
            m_rev = reverse;
            m_idx = reverse ? 3 : 0;
          end else begin
            m_idx = m_rev ? m_idx - 1 : m_idx + 1;
          end
        end else if (tick_ok) begin
          expq.push_back(-1);
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_sat < 3) m_cnt_sat++;
        end
        if (push) m_q.push_back(word_data);
      end
      if (!enable) m_audio = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (audio_valid && underrun) begin
        n_checks++; n_fail++;
        $display("FAIL both_pulses: audio_valid and underrun together at %0t", $time);
      end else if (audio_valid || underrun) begin
        if (expq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: valid=%0b underrun=%0b, none expected", audio_valid, underrun);
        end else begin
          int e;
          e = expq.pop_front();
          if (audio_valid) begin
            chk("event_kind", 32'(audio_valid), (e >= 0) ? 32'd1 : 32'd0);
            if (e >= 0) chk("sample_byte", 32'(audio_out), 32'(e));
            obs_log.push_back(int'(audio_out));
          end else begin
            chk("underrun_kind", 32'(underrun), (e < 0) ? 32'd1 : 32'd0);
          end
        end
      end else if (expq.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL missing_event: expected %0d, got no pulse", expq[0]);
        void'(expq.pop_front());
      end
      chk("audio_out", 32'(audio_out), 32'(m_audio));
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("word_ready", 32'(word_ready), (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
      chk("underrun_count", 32'(underrun_count), 32'(m_cnt));
      chk("sat_count", 32'(s_underrun_count), 32'(m_cnt_sat));
      chk("sat_audio", 32'(s_audio_out), 32'(m_audio));
      chk("sat_pulses", {29'd0, s_audio_valid, s_underrun, s_word_ready},
          {29'd0, audio_valid, underrun, word_ready});
      chk("sat_level", 32'(s_fifo_level), 32'(m_q.size()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic t, input logic v, input logic [31:0] d);
    sample_tick = t; word_valid = v; word_data = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    sample_tick = 0; word_valid = 0; flush = 0; enable = 1; reverse = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    obs_log.delete();
    @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int exp[8], input int n);
    chk({name, "_count"}, 32'(obs_log.size()), 32'(n));
    for (int i = 0; i < n && i < obs_log.size(); i++)
      chk(name, 32'(obs_log[i]), 32'(exp[i]));
  endtask

  initial begin
    int fwd_exp[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int rev_exp[8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66, 8'h77, 8'h88};
    int rst_exp[8] = '{8'hd4, 8'hc3, 8'hb2, 8'ha1, 0, 0, 0, 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_audio", 32'(audio_out), 32'd0);
    chk("rst_ready", 32'(word_ready), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    reset = 0;
    @(negedge clk);

    // forward unpack
    do_reset();
    cyc(0, 1, 32'h44332211);
    cyc(0, 1, 32'h88776655);
    repeat (8) cyc(1, 0, 0);
    cyc(0, 0, 0); #1;
    chk_log("fwd_byte", fwd_exp, 8);
    chk("fwd_level", 32'(fifo_level), 32'd0);
    chk("fwd_underruns", 32'(underrun_count), 32'd0);

    // reverse unpack with mid-word direction change
    do_reset();
    reverse = 1; flush = 1; cyc(0, 0, 0); flush = 0;
    cyc(0, 1, 32'h44332211);
    cyc(1, 0, 0); cyc(1, 0, 0);
    reverse = 0;
    cyc(1, 1, 32'h88776655);
    cyc(1, 0, 0);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 0, 0); #1;
    chk_log("rev_byte", rev_exp, 8);

    // backpressure
    do_reset();
    repeat (6) cyc(0, 1, $urandom);
    #1;
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_ready", 32'(word_ready), 32'd0);
    repeat (4) cyc(1, 0, 0);
    #1;
    chk("bp_ready_back", 32'(word_ready), 32'd1);
    chk("bp_level_after", 32'(fifo_level), 32'd3);

    // underrun and saturation
    do_reset();
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0); #1;
    chk("ur_count", 32'(underrun_count), 32'd3);
    chk("ur_audio", 32'(audio_out), 32'd0);
    cyc(1, 0, 0); cyc(0, 0, 0); #1;
    chk("ur_sat", 32'(s_underrun_count), 32'd3);
    chk("ur_count4", 32'(underrun_count), 32'd4);

    // enable low, then flush with a concurrent push
    do_reset();
    cyc(0, 1, 32'h0badf00d);
    cyc(1, 1, 32'h12345678);
    cyc(0, 0, 0);
    enable = 0;
    repeat (3) cyc(1, 0, 0);
    #1;
    chk("dis_audio", 32'(audio_out), 32'd0);
    chk("dis_level", 32'(fifo_level), 32'd2);
    enable = 1; flush = 1;
    cyc(1, 1, 32'hdeadbeef);
    flush = 0;
    #1;
    chk("flush_level", 32'(fifo_level), 32'd0);

    // async reset mid-word
    do_reset();
    cyc(0, 1, 32'h44332211);
    cyc(1, 0, 0); cyc(1, 0, 0);
    #2 reset = 1;
    #1;
    chk("arst_audio", 32'(audio_out), 32'd0);
    chk("arst_valid", 32'(audio_valid), 32'd0);
    chk("arst_ready", 32'(word_ready), 32'd1);
    chk("arst_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    reset = 0; reverse = 1;
    obs_log.delete();
    cyc(0, 1, 32'ha1b2c3d4);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 0, 0); #1;
    rst_exp = '{8'hd4, 8'hc3, 8'hb2, 8'ha1, 0, 0, 0, 0};
    chk_log("arst_byte", rst_exp, 4);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int tick_pct;
      tick_pct = (i < 1500) ? 30 : 90;
      enable  = ($urandom_range(99) < 95);
      flush   = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 10) reverse = ~reverse;
      cyc($urandom_range(99) < tick_pct, $urandom_range(99) < 60, $urandom);
    end
    flush = 0; enable = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
